// File: rtl/coreUtils.sv
// Decode types shared by the decode stage and its field decoder: opcodes, legal
// funct3/funct7 values, ALU codes (base and M-extension) and the control bundle.
package coreUtils;

    localparam int IMM_W = 64;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_ADD_SUB   = 3'b000;
    localparam logic [2:0] F3_SLL       = 3'b001;
    localparam logic [2:0] F3_SLTU      = 3'b011;
    localparam logic [2:0] F3_SR        = 3'b101;
    localparam logic [2:0] F3_JALR      = 3'b000;
    localparam logic [2:0] F3_STORE_MAX = 3'b010;

    typedef enum logic [4:0] {
        ALU_ADD      = 5'b00000,
        ALU_SLL      = 5'b00001,
        ALU_SLT      = 5'b00010,
        ALU_SLTU     = 5'b00011,
        ALU_XOR      = 5'b00100,
        ALU_SRL      = 5'b00101,
        ALU_OR       = 5'b00110,
        ALU_AND      = 5'b00111,
        ALU_SUB      = 5'b01000,
        ALU_SLTU_IMM = 5'b01011,
        ALU_SRA      = 5'b01101,
        ALU_MUL      = 5'b10000,
        ALU_MULH     = 5'b10001,
        ALU_MULHSU   = 5'b10010,
        ALU_MULHU    = 5'b10011,
        ALU_DIV      = 5'b10100,
        ALU_DIVU     = 5'b10101,
        ALU_REM      = 5'b10110,
        ALU_REMU     = 5'b10111
    } alu_codes_t;

    typedef struct packed {
        logic             Wreg;
        logic             Wmem;
        logic             Rmem;
        logic             aluImm;
        logic             aluPc;
        logic             branch;
        logic             jump;
        logic [2:0]       f3;
        alu_codes_t       alu;
        logic [IMM_W-1:0] imm;
    } control_signals_t;

    function automatic logic load_f3_legal(input logic [2:0] f3);
        return !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    endfunction

    function automatic logic branch_f3_legal(input logic [2:0] f3);
        return !(f3 == 3'b010 || f3 == 3'b011);
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Combinational field decoder: turns a raw instruction word into the control
// bundle, register indices and an illegal flag.
module decode_comb
    import coreUtils::*;
#(
    parameter int XLEN = 32,
    parameter bit EN_M = 1'b0
) (
    input  logic [31:0]      instr_i,
    output control_signals_t ctrl_o,
    output logic [4:0]       rd_o,
    output logic [4:0]       rs1_o,
    output logic [4:0]       rs2_o,
    output logic             illegal_o
);
    logic [6:0]       opc;
    logic [6:0]       f7;
    logic [2:0]       f3;
    logic [31:0]      imm32;
    logic             illegal;
    control_signals_t ctrl;

    assign opc   = instr_i[6:0];
    assign f3    = instr_i[14:12];
    assign f7    = instr_i[31:25];
    assign rd_o  = instr_i[11:7];
    assign rs1_o = instr_i[19:15];
    assign rs2_o = instr_i[24:20];

    always_comb begin
        ctrl    = '0;
        imm32   = '0;
        illegal = 1'b0;
        ctrl.f3 = f3;
        case (opc)
            OPC_LUI, OPC_AUIPC: begin
                ctrl.Wreg   = 1'b1;
                ctrl.aluImm = 1'b1;
                ctrl.aluPc  = (opc == OPC_AUIPC);
                imm32       = {instr_i[31:12], 12'b0};
            end
            OPC_OPIMM: begin
                ctrl.Wreg   = 1'b1;
                ctrl.aluImm = 1'b1;
                imm32       = {{20{instr_i[31]}}, instr_i[31:20]};
                case (f3)
                    F3_SR: begin
                        ctrl.alu = alu_codes_t'({1'b0, instr_i[30], f3});
                        illegal  = (f7 != F7_BASE) && (f7 != F7_ALT);
                    end
                    F3_SLL: begin
                        ctrl.alu = ALU_SLL;
                        illegal  = (f7 != F7_BASE);
                    end
                    F3_SLTU: ctrl.alu = ALU_SLTU_IMM;
                    default: ctrl.alu = alu_codes_t'({2'b00, f3});
                endcase
            end
            OPC_OP: begin
                ctrl.Wreg = 1'b1;
                if (EN_M && f7 == F7_MULDIV) begin
                    ctrl.alu = alu_codes_t'({2'b10, f3});
                end else begin
                    ctrl.alu = alu_codes_t'({1'b0, instr_i[30], f3});
                    illegal  = !((f7 == F7_BASE) ||
                                 (f7 == F7_ALT && (f3 == F3_ADD_SUB || f3 == F3_SR)));
                end
            end
            OPC_LOAD: begin
                ctrl.Wreg   = 1'b1;
                ctrl.Rmem   = 1'b1;
                ctrl.aluImm = 1'b1;
                imm32       = {{20{instr_i[31]}}, instr_i[31:20]};
                illegal     = !load_f3_legal(f3);
            end
            OPC_STORE: begin
                ctrl.Wmem   = 1'b1;
                ctrl.aluImm = 1'b1;
                imm32       = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
                illegal     = (f3 > F3_STORE_MAX);
            end
            OPC_JAL: begin
                ctrl.Wreg  = 1'b1;
                ctrl.jump  = 1'b1;
                ctrl.aluPc = 1'b1;
                imm32      = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20],
                              instr_i[30:21], 1'b0};
            end
            OPC_JALR: begin
                ctrl.Wreg   = 1'b1;
                ctrl.jump   = 1'b1;
                ctrl.aluImm = 1'b1;
                imm32       = {{20{instr_i[31]}}, instr_i[31:20]};
                illegal     = (f3 != F3_JALR);
            end
            OPC_BRANCH: begin
                ctrl.branch = 1'b1;
                ctrl.aluPc  = 1'b1;
                imm32       = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25],
                               instr_i[11:8], 1'b0};
                illegal     = !branch_f3_legal(f3);
            end
            default: illegal = 1'b1;
        endcase
        if (instr_i[1:0] != 2'b11) illegal = 1'b1;
        if (rd_o == 5'd0) ctrl.Wreg = 1'b0;
        // Bits above XLEN stay zero so a 32-bit core never sees sign bits past its datapath.
        ctrl.imm = {{(IMM_W-32){imm32[31] && (XLEN == 64)}}, imm32};
        if (illegal) ctrl = '0;
    end

    assign ctrl_o    = ctrl;
    assign illegal_o = illegal;

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: decode_comb at the input feeding either a 2-entry skid
// buffer (registered in_ready) or a single output register.
module decode_stage
    import coreUtils::*;
#(
    parameter int XLEN = 32,
    parameter bit EN_M = 1'b0,
    parameter bit SKID = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output control_signals_t out_ctrl,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic             out_illegal
);
    typedef struct packed {
        control_signals_t ctrl;
        logic [XLEN-1:0]  pc;
        logic [4:0]       rd;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic             illegal;
    } entry_t;

    control_signals_t dec_ctrl;
    logic [4:0]       dec_rd, dec_rs1, dec_rs2;
    logic             dec_illegal;
    entry_t           dec, head;
    entry_t           e0_q, e0_d, e1_q, e1_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             push, pop;

    decode_comb #(
        .XLEN (XLEN),
        .EN_M (EN_M)
    ) u_decode_comb (
        .instr_i   (in_instr),
        .ctrl_o    (dec_ctrl),
        .rd_o      (dec_rd),
        .rs1_o     (dec_rs1),
        .rs2_o     (dec_rs2),
        .illegal_o (dec_illegal)
    );

    assign dec = '{ctrl: dec_ctrl, pc: in_pc, rd: dec_rd, rs1: dec_rs1,
                   rs2: dec_rs2, illegal: dec_illegal};

    // in_ready and the outputs are gated by rst so they read idle during the reset cycle itself.
    assign in_ready  = !rst && (SKID ? (cnt_q != 2'd2) : (cnt_q == 2'd0 || out_ready));
    assign out_valid = !rst && (cnt_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) e0_d = dec;
                else               e1_d = dec;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                e0_d  = e1_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    e0_d = dec;
                end else begin
                    e0_d = e1_q;
                    e1_d = dec;
                end
            end
            default: ;
        endcase
        if (flush) cnt_d = 2'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 2'd0;
            e0_q  <= '0;
            e1_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            e0_q  <= e0_d;
            e1_q  <= e1_d;
        end
    end

    assign head        = rst ? '0 : e0_q;
    assign out_ctrl    = head.ctrl;
    assign out_pc      = head.pc;
    assign out_rd      = head.rd;
    assign out_rs1     = head.rs1;
    assign out_rs2     = head.rs2;
    assign out_illegal = head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench: instance A (XLEN=32, EN_M=0, SKID=1) and instance B
// (XLEN=64, EN_M=1, SKID=0) with hand-computed expectations.
module tb_decode_stage;
    import coreUtils::*;

    logic clk, rst;

    logic             flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_illegal_a;
    logic [31:0]      in_instr_a, in_pc_a, out_pc_a;
    control_signals_t out_ctrl_a;
    logic [4:0]       out_rd_a, out_rs1_a, out_rs2_a;

    logic             flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_illegal_b;
    logic [31:0]      in_instr_b;
    logic [63:0]      in_pc_b, out_pc_b;
    control_signals_t out_ctrl_b;
    logic [4:0]       out_rd_b, out_rs1_b, out_rs2_b;

    int n_checks = 0;
    int n_errors = 0;

    decode_stage #(.XLEN(32), .EN_M(1'b0), .SKID(1'b1)) dut_a (
        .clk(clk), .rst(rst), .flush(flush_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_instr(in_instr_a), .in_pc(in_pc_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_ctrl(out_ctrl_a), .out_pc(out_pc_a), .out_rd(out_rd_a), .out_rs1(out_rs1_a),
        .out_rs2(out_rs2_a), .out_illegal(out_illegal_a)
    );

    decode_stage #(.XLEN(64), .EN_M(1'b1), .SKID(1'b0)) dut_b (
        .clk(clk), .rst(rst), .flush(flush_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_instr(in_instr_b), .in_pc(in_pc_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_ctrl(out_ctrl_b), .out_pc(out_pc_b), .out_rd(out_rd_b), .out_rs1(out_rs1_b),
        .out_rs2(out_rs2_b), .out_illegal(out_illegal_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        in_valid_a = 1'b1; in_instr_a = instr; in_pc_a = pc;
        in_valid_b = 1'b1; in_instr_b = instr; in_pc_b = {32'h0, pc};
        tick();
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        flush_a = 1'b0; in_valid_a = 1'b0; in_instr_a = '0; in_pc_a = '0; out_ready_a = 1'b1;
        flush_b = 1'b0; in_valid_b = 1'b0; in_instr_b = '0; in_pc_b = '0; out_ready_b = 1'b1;
        tick();
        tick();
        chk("rst_valid_a",   128'(out_valid_a),   128'(1'b0));
        chk("rst_ready_a",   128'(in_ready_a),    128'(1'b0));
        chk("rst_illegal_a", 128'(out_illegal_a), 128'(1'b0));
        chk("rst_pc_a",      128'(out_pc_a),      128'(32'h0));
        chk("rst_ctrl_a",    128'(out_ctrl_a),    128'(0));
        chk("rst_valid_b",   128'(out_valid_b),   128'(1'b0));
        chk("rst_ready_b",   128'(in_ready_b),    128'(1'b0));

        rst = 1'b0;
        #1;
        chk("post_rst_ready_a", 128'(in_ready_a), 128'(1'b1));
        chk("post_rst_ready_b", 128'(in_ready_b), 128'(1'b1));

        send(32'h00500093, 32'h100);  // addi x1,x0,5
        chk("addi_valid_a",  128'(out_valid_a),       128'(1'b1));
        chk("addi_rd_a",     128'(out_rd_a),          128'(5'd1));
        chk("addi_imm_a",    128'(out_ctrl_a.imm),    128'(64'd5));
        chk("addi_wreg_a",   128'(out_ctrl_a.Wreg),   128'(1'b1));
        chk("addi_aluimm_a", 128'(out_ctrl_a.aluImm), 128'(1'b1));
        chk("addi_ill_a",    128'(out_illegal_a),     128'(1'b0));
        chk("addi_pc_a",     128'(out_pc_a),          128'(32'h100));
        chk("addi_alu_a",    128'(out_ctrl_a.alu),    128'(ALU_ADD));
        chk("addi_valid_b",  128'(out_valid_b),       128'(1'b1));
        chk("addi_imm_b",    128'(out_ctrl_b.imm),    128'(64'd5));

        send(32'h123452B7, 32'h104);  // lui x5,0x12345
        chk("lui_imm_a", 128'(out_ctrl_a.imm), 128'(64'h0000_0000_1234_5000));
        chk("lui_rd_a",  128'(out_rd_a),       128'(5'd5));
        chk("lui_imm_b", 128'(out_ctrl_b.imm), 128'(64'h0000_0000_1234_5000));
        chk("lui_pc_b",  128'(out_pc_b),       128'(64'h104));

        send(32'hFFF00093, 32'h108);  // addi x1,x0,-1
        chk("neg_imm_a", 128'(out_ctrl_a.imm), 128'(64'h0000_0000_FFFF_FFFF));
        chk("neg_imm_b", 128'(out_ctrl_b.imm), 128'(64'hFFFF_FFFF_FFFF_FFFF));

        send(32'h00000000, 32'h200);
        chk("zero_ill_a",  128'(out_illegal_a),   128'(1'b1));
        chk("zero_wreg_a", 128'(out_ctrl_a.Wreg), 128'(1'b0));
        chk("zero_ctrl_a", 128'(out_ctrl_a),      128'(0));
        chk("zero_pc_a",   128'(out_pc_a),        128'(32'h200));
        chk("zero_ill_b",  128'(out_illegal_b),   128'(1'b1));

        send(32'h022081B3, 32'h204);  // mul x3,x1,x2
        chk("mul_ill_a",  128'(out_illegal_a),   128'(1'b1));
        chk("mul_wreg_a", 128'(out_ctrl_a.Wreg), 128'(1'b0));
        chk("mul_ill_b",  128'(out_illegal_b),   128'(1'b0));
        chk("mul_alu_b",  128'(out_ctrl_b.alu),  128'(ALU_MUL));
        chk("mul_wreg_b", 128'(out_ctrl_b.Wreg), 128'(1'b1));
        chk("mul_rd_b",   128'(out_rd_b),        128'(5'd3));
        chk("mul_rs1_b",  128'(out_rs1_b),       128'(5'd1));
        chk("mul_rs2_b",  128'(out_rs2_b),       128'(5'd2));

        send(32'h00000013, 32'h208);  // addi x0,x0,0
        chk("nop_ill_a",    128'(out_illegal_a),     128'(1'b0));
        chk("nop_wreg_a",   128'(out_ctrl_a.Wreg),   128'(1'b0));
        chk("nop_aluimm_a", 128'(out_ctrl_a.aluImm), 128'(1'b1));

        send(32'h4030D093, 32'h20C);  // srai x1,x1,3
        chk("srai_alu_a", 128'(out_ctrl_a.alu), 128'(ALU_SRA));
        chk("srai_ill_a", 128'(out_illegal_a),  128'(1'b0));

        send(32'h00103093, 32'h210);  // sltiu x1,x0,1
        chk("sltiu_alu_a", 128'(out_ctrl_a.alu), 128'(ALU_SLTU_IMM));

        send(32'h0020A423, 32'h214);  // sw x2,8(x1)
        chk("sw_wmem_a", 128'(out_ctrl_a.Wmem), 128'(1'b1));
        chk("sw_wreg_a", 128'(out_ctrl_a.Wreg), 128'(1'b0));
        chk("sw_imm_a",  128'(out_ctrl_a.imm),  128'(64'd8));
        chk("sw_rs1_a",  128'(out_rs1_a),       128'(5'd1));
        chk("sw_rs2_a",  128'(out_rs2_a),       128'(5'd2));
        chk("sw_ill_a",  128'(out_illegal_a),   128'(1'b0));

        send(32'h00003083, 32'h218);  // ld x1,0(x0) -- LOAD f3=011
        chk("ld_ill_a", 128'(out_illegal_a), 128'(1'b1));

        send(32'h00009067, 32'h21C);  // jalr with f3=001
        chk("jalr_ill_a", 128'(out_illegal_a), 128'(1'b1));

        tick();
        chk("idle_valid_a", 128'(out_valid_a), 128'(1'b0));
        chk("idle_valid_b", 128'(out_valid_b), 128'(1'b0));

        // Backpressure on the skid buffer.
        out_ready_a = 1'b0;
        in_valid_a = 1'b1; in_instr_a = 32'h00100093; in_pc_a = 32'h300;
        #1;
        chk("bp_ready0", 128'(in_ready_a), 128'(1'b1));
        tick();
        in_instr_a = 32'h00200113; in_pc_a = 32'h304;
        #1;
        chk("bp_valid1", 128'(out_valid_a), 128'(1'b1));
        chk("bp_ready1", 128'(in_ready_a),  128'(1'b1));
        chk("bp_pc1",    128'(out_pc_a),    128'(32'h300));
        tick();
        in_instr_a = 32'h00300193; in_pc_a = 32'h308;
        #1;
        chk("bp_full_ready", 128'(in_ready_a), 128'(1'b0));
        tick();
        chk("bp_stall_pc",    128'(out_pc_a),   128'(32'h300));
        chk("bp_stall_rd",    128'(out_rd_a),   128'(5'd1));
        chk("bp_stall_ready", 128'(in_ready_a), 128'(1'b0));
        tick();
        out_ready_a = 1'b1;
        tick();
        chk("bp_order2_pc", 128'(out_pc_a),   128'(32'h304));
        chk("bp_order2_rd", 128'(out_rd_a),   128'(5'd2));
        chk("bp_ready_one", 128'(in_ready_a), 128'(1'b1));
        tick();
        in_valid_a = 1'b0;
        chk("bp_order3_pc", 128'(out_pc_a),    128'(32'h308));
        chk("bp_order3_rd", 128'(out_rd_a),    128'(5'd3));
        chk("bp_order3_v",  128'(out_valid_a), 128'(1'b1));
        tick();
        chk("bp_drain", 128'(out_valid_a), 128'(1'b0));

        // Flush while full with an input offered.
        out_ready_a = 1'b0;
        in_valid_a = 1'b1; in_instr_a = 32'h00100093; in_pc_a = 32'h400;
        tick();
        in_instr_a = 32'h00200113; in_pc_a = 32'h404;
        tick();
        in_instr_a = 32'h00300193; in_pc_a = 32'h408;
        flush_a = 1'b1;
        tick();
        flush_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b1;
        chk("fl_valid", 128'(out_valid_a), 128'(1'b0));
        chk("fl_ready", 128'(in_ready_a),  128'(1'b1));
        tick();
        chk("fl_still_empty", 128'(out_valid_a), 128'(1'b0));

        // Flush on B drops the instruction accepted in the same cycle.
        in_valid_b = 1'b1; in_instr_b = 32'h00500093; in_pc_b = 64'h500;
        flush_b = 1'b1;
        #1;
        chk("flb_ready", 128'(in_ready_b), 128'(1'b1));
        tick();
        flush_b = 1'b0; in_valid_b = 1'b0;
        chk("flb_valid", 128'(out_valid_b), 128'(1'b0));

        // Single register: in_ready follows out_ready combinationally when holding an entry.
        out_ready_b = 1'b0;
        in_valid_b = 1'b1; in_instr_b = 32'h00100093; in_pc_b = 64'h600;
        tick();
        in_instr_b = 32'h00200113; in_pc_b = 64'h604;
        #1;
        chk("b_ready_stall", 128'(in_ready_b), 128'(1'b0));
        chk("b_hold_pc",     128'(out_pc_b),   128'(64'h600));
        out_ready_b = 1'b1;
        #1;
        chk("b_ready_comb", 128'(in_ready_b), 128'(1'b1));
        tick();
        in_valid_b = 1'b0;
        chk("b_next_pc", 128'(out_pc_b), 128'(64'h604));
        chk("b_next_rd", 128'(out_rd_b), 128'(5'd2));
        tick();
        chk("b_drain", 128'(out_valid_b), 128'(1'b0));

        // Reset during a stall discards both held entries.
        out_ready_a = 1'b0;
        in_valid_a = 1'b1; in_instr_a = 32'h00100093; in_pc_a = 32'h700;
        tick();
        in_instr_a = 32'h00200113; in_pc_a = 32'h704;
        tick();
        in_valid_a = 1'b0;
        rst = 1'b1;
        #1;
        chk("rs_valid", 128'(out_valid_a), 128'(1'b0));
        chk("rs_ready", 128'(in_ready_a),  128'(1'b0));
        chk("rs_pc",    128'(out_pc_a),    128'(32'h0));
        tick();
        rst = 1'b0; out_ready_a = 1'b1;
        #1;
        chk("rs_ready_after", 128'(in_ready_a),  128'(1'b1));
        chk("rs_valid_after", 128'(out_valid_a), 128'(1'b0));
        tick();
        chk("rs_empty", 128'(out_valid_a), 128'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
